key_cmd_queue: RTL and testbench
================================

// Module: key_cmd_queue
// PURPOSE
//   Consumer side of the key debouncers' pulse interface. Turns single-cycle press pulses
//   from NKEYS debouncers, plus the synchronized active-low held levels, into a queued
//   command stream for the game controller. Adds auto-repeat for held keys and delivers
//   commands over a valid/ready handshake through a DEPTH-entry FIFO.
// PARAMETERS
//   NKEYS        4           number of keys (0=left,1=right,2=rotate,3=down)
//   KW           2           key index width, = clog2(NKEYS)
//   DEPTH        4           FIFO entries, power of 2, >=2
//   REPEAT_MASK  4'b1011     bit i=1: key i auto-repeats
//   REPEAT_DELAY 25_000_000  cycles from press pulse to first repeat, >=2
//   REPEAT_RATE  5_000_000   cycles between later repeats, >=2
//   CNT_W        26          repeat counter width, must hold REPEAT_DELAY
// PORTS
//   clk          in   1          system clock
//   rst_n        in   1          asynchronous reset, active-low
//   key_pulse    in   NKEYS      1-cycle press pulses from the debouncers
//   key_held_n   in   NKEYS      synchronized raw level; 0 = pressed
//   cmd_ready    in   1          consumer accepts the head entry
//   cmd_valid    out  1          FIFO non-empty
//   cmd_key      out  KW         key index of the head entry
//   cmd_repeat   out  1          head entry is an auto-repeat (0 = fresh press)
//   fifo_level   out  clog2(DEPTH)+1  current occupancy, 0..DEPTH
//   overflow     out  1          sticky: an event was dropped
// BEHAVIOUR
//   Reset: every output is 0. All pending bits, FIFO pointers and repeat FSMs are cleared.
//   Reset mid-operation discards all queued and pending events.
//   Event sources per key i:
//     - press: key_pulse[i]=1
//     - repeat: FSM below
//     - press wins if both occur in the same cycle
//   Pending stage: each key has pend[i] and pend_rep[i], set on the edge after the event.
//     - Event while pend[i]=1 and pend[i] not drained this cycle: drop it, set overflow.
//     - Event in the same cycle pend[i] drains: pend[i] stays 1 with the new flag, no drop.
//   Arbiter: each cycle, if fifo_level<DEPTH, pick the lowest-index pend[i].
//     - Write {pend_rep[i], i} into the FIFO and clear pend[i].
//     - One write per cycle. FIFO full: nothing drains; pending bits hold.
//     - Push is decided on the registered level and ignores a same-cycle pop.
//   Latency: pulse sampled at edge N. pend set at N. FIFO written and cmd_valid=1 after N+1.
//     This is 2 cycles from pulse to cmd_valid when empty and uncontended.
//   FIFO: cmd_key and cmd_repeat are driven from the head entry.
//     - Pop on cmd_valid & cmd_ready. Push and pop in the same cycle leave the level unchanged.
//     - Pointers wrap modulo DEPTH.
//     - cmd_key and cmd_repeat hold their value while cmd_valid=0.
//   Repeat FSM, key i, only when REPEAT_MASK[i]=1 (otherwise stays IDLE):
//     - IDLE -> DELAY on key_pulse[i]; cnt=0.
//     - DELAY: cnt++ each cycle. At cnt==REPEAT_DELAY-1: raise a repeat event, cnt=0, go to REPEAT.
//     - REPEAT: cnt++. At cnt==REPEAT_RATE-1: raise a repeat event, cnt=0.
//     - Any state: key_held_n[i]=1 -> IDLE, cnt=0. Release takes priority over a repeat due that cycle.
//     - key_pulse[i] in DELAY or REPEAT restarts DELAY with cnt=0.
//   overflow clears only on reset.
// TESTING  (NKEYS=4, DEPTH=4, REPEAT_DELAY=8, REPEAT_RATE=4, REPEAT_MASK=4'b1011)
//   1. Pulse key 2 at cycle 0, cmd_ready=1 -> cmd_valid=1 at cycle 2 with key=2, repeat=0.
//      Level returns to 0 at cycle 3.
//   2. Pulse keys 0,1,3 together, cmd_ready=0 -> entries 0,1,3 in that order, level=3.
//      overflow=0.
//   3. Pulse key 1 and hold key_held_n[1]=0, cmd_ready=1 -> press entry, then repeat entries.
//      First repeat is 8 cycles after the pulse, later ones every 4 cycles.
//      Release -> no further repeats. Key 2 held the same way -> no repeats.
//   4. cmd_ready=0; pulse key 0 six times, 2 cycles apart -> level saturates at 4.
//      pend[0] holds 1 entry. The next pulse sets overflow=1.
//      Then cmd_ready=1 -> 5 entries drain in order.
//   5. FIFO at level 2 with cmd_ready=1 and a new event arriving -> level stays 2.
//      Order is preserved across pointer wrap (>=10 entries total).
//   6. Assert rst_n=0 mid-stream with level=3 and a repeat active.
//      -> all outputs 0 immediately; no spurious entries after release.

Source files
------------

// File: rtl/key_cmd_if.sv
// Key-event inputs and queued command outputs of key_cmd_queue.
// master = stimulus/consumer side, slave = the queue itself.
interface key_cmd_if #(
    parameter int NKEYS = 4,
    parameter int KW    = 2,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [NKEYS-1:0] key_pulse;
    logic [NKEYS-1:0] key_held_n;
    logic             cmd_ready;
    logic             cmd_valid;
    logic [KW-1:0]    cmd_key;
    logic             cmd_repeat;
    logic [LW-1:0]    fifo_level;
    logic             overflow;

    modport master (
        output key_pulse, key_held_n, cmd_ready,
        input  cmd_valid, cmd_key, cmd_repeat, fifo_level, overflow
    );

    modport slave (
        input  key_pulse, key_held_n, cmd_ready,
        output cmd_valid, cmd_key, cmd_repeat, fifo_level, overflow
    );
endinterface

// File: rtl/key_cmd_queue.sv
// Key press pulses + auto-repeat -> per-key pending bits -> priority arbiter -> DEPTH-entry FIFO.
// Pulse to cmd_valid is 2 cycles; a full FIFO stalls pending bits, a second event on a busy key is dropped (sticky overflow).
module key_cmd_queue #(
    parameter int               NKEYS        = 4,
    parameter int               KW           = 2,
    parameter int               DEPTH        = 4,
    parameter logic [NKEYS-1:0] REPEAT_MASK  = 4'b1011,
    parameter int               REPEAT_DELAY = 25_000_000,
    parameter int               REPEAT_RATE  = 5_000_000,
    parameter int               CNT_W        = 26
) (
    input logic       clk,
    input logic       rst_n,
    key_cmd_if.slave  bus_if
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = KW + 1;
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {R_IDLE, R_DELAY, R_REPEAT} rep_state_e;

    rep_state_e       st_q  [NKEYS];
    rep_state_e       st_d  [NKEYS];
    logic [CNT_W-1:0] cnt_q [NKEYS];
    logic [CNT_W-1:0] cnt_d [NKEYS];
    logic [NKEYS-1:0] rep_ev;

    logic [NKEYS-1:0] pend_q, pend_d, prep_q, prep_d;
    logic [NKEYS-1:0] ev, ev_rep, grant;
    logic             ovf_q, ovf_set;
    logic             push, pop, push_rep, valid;
    logic [KW-1:0]    push_key;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [LW-1:0]    level_q;
    logic [EW-1:0]    hold_q, head;

    // Release wins over everything, then a fresh press restarts the delay.
    always_comb begin
        for (int i = 0; i < NKEYS; i++) begin
            st_d[i]   = st_q[i];
            cnt_d[i]  = cnt_q[i];
            rep_ev[i] = 1'b0;
            if (!REPEAT_MASK[i] || bus_if.key_held_n[i]) begin
                st_d[i]  = R_IDLE;
                cnt_d[i] = '0;
            end else if (bus_if.key_pulse[i]) begin
                st_d[i]  = R_DELAY;
                cnt_d[i] = '0;
            end else begin
                case (st_q[i])
                    R_DELAY: begin
                        if (cnt_q[i] == DELAY_LAST) begin
                            rep_ev[i] = 1'b1;
                            cnt_d[i]  = '0;
                            st_d[i]   = R_REPEAT;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    R_REPEAT: begin
                        if (cnt_q[i] == RATE_LAST) begin
                            rep_ev[i] = 1'b1;
                            cnt_d[i]  = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Lowest index wins; push uses the registered level, ignoring a same-cycle pop.
    always_comb begin
        grant    = '0;
        push_key = '0;
        if (level_q < LW'(DEPTH)) begin
            for (int i = NKEYS - 1; i >= 0; i--) begin
                if (pend_q[i]) begin
                    grant    = '0;
                    grant[i] = 1'b1;
                    push_key = KW'(i);
                end
            end
        end
        push     = |grant;
        push_rep = prep_q[push_key];
    end

    always_comb begin
        ev      = bus_if.key_pulse | rep_ev;
        ev_rep  = ~bus_if.key_pulse & rep_ev;
        pend_d  = pend_q;
        prep_d  = prep_q;
        ovf_set = 1'b0;
        for (int i = 0; i < NKEYS; i++) begin
            if (ev[i]) begin
                if (pend_q[i] && !grant[i]) begin
                    ovf_set = 1'b1;
                end else begin
                    pend_d[i] = 1'b1;
                    prep_d[i] = ev_rep[i];
                end
            end else if (grant[i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    assign valid = (level_q != '0);
    assign pop   = valid & bus_if.cmd_ready;
    // An empty FIFO shows the last head so the outputs do not wander onto stale slots.
    assign head  = valid ? mem_q[rd_q] : hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            for (int i = 0; i < NKEYS; i++) begin
                st_q[i]  <= R_IDLE;
                cnt_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            hold_q  <= '0;
            pend_q  <= '0;
            prep_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NKEYS; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            if (push) begin
                mem_q[wr_q] <= {push_rep, push_key};
                wr_q        <= wr_q + PW'(1);
            end
            if (pop) rd_q <= rd_q + PW'(1);
            level_q <= level_q + LW'(push) - LW'(pop);
            hold_q  <= head;
            pend_q  <= pend_d;
            prep_q  <= prep_d;
            if (ovf_set) ovf_q <= 1'b1;
        end
    end

    assign bus_if.cmd_valid  = valid;
    assign bus_if.cmd_key    = head[KW-1:0];
    assign bus_if.cmd_repeat = head[KW];
    assign bus_if.fifo_level = level_q;
    assign bus_if.overflow   = ovf_q;
endmodule

// File: tb/tb_key_cmd_queue.sv
// Directed bench for key_cmd_queue: per-cycle vector table plus hand sequences for repeat, saturation, wrap and reset.
module tb_key_cmd_queue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    key_cmd_if #(.NKEYS(4), .KW(2), .DEPTH(4)) bus_if ();

    key_cmd_queue #(
        .NKEYS(4), .KW(2), .DEPTH(4), .REPEAT_MASK(4'b1011),
        .REPEAT_DELAY(8), .REPEAT_RATE(4), .CNT_W(5)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus_if.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int c; int k; int r; } ent_t;
    ent_t log_q[$];
    always @(negedge clk)
        if (rst_n && bus_if.cmd_valid && bus_if.cmd_ready)
            log_q.push_back('{cyc, int'(bus_if.cmd_key), int'(bus_if.cmd_repeat)});

    typedef struct {
        logic [3:0] pulse;
        logic       ready;
        logic       ev;
        logic [1:0] ek;
        logic       er;
        logic [2:0] el;
        logic       eo;
    } vec_t;
    vec_t tbl [13];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) tick();
    endtask

    int p;
    int exp_c [4];
    int exp_r [4];
    int seq   [12];
    int exp_k [$];

    initial begin
        bus_if.key_pulse  = 4'b0000;
        bus_if.key_held_n = 4'b1111;
        bus_if.cmd_ready  = 1'b0;

        // Tests 1 and 2: single press, then three simultaneous presses under backpressure.
        tbl[0]  = '{4'b0100, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 1'b0};
        tbl[1]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 1'b0};
        tbl[2]  = '{4'b0000, 1'b1, 1'b1, 2'd2, 1'b0, 3'd1, 1'b0};
        tbl[3]  = '{4'b0000, 1'b1, 1'b0, 2'd2, 1'b0, 3'd0, 1'b0};
        tbl[4]  = '{4'b1011, 1'b0, 1'b0, 2'd2, 1'b0, 3'd0, 1'b0};
        tbl[5]  = '{4'b0000, 1'b0, 1'b0, 2'd2, 1'b0, 3'd0, 1'b0};
        tbl[6]  = '{4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 3'd1, 1'b0};
        tbl[7]  = '{4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 3'd2, 1'b0};
        tbl[8]  = '{4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 3'd3, 1'b0};
        tbl[9]  = '{4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 3'd3, 1'b0};
        tbl[10] = '{4'b0000, 1'b1, 1'b1, 2'd1, 1'b0, 3'd2, 1'b0};
        tbl[11] = '{4'b0000, 1'b1, 1'b1, 2'd3, 1'b0, 3'd1, 1'b0};
        tbl[12] = '{4'b0000, 1'b1, 1'b0, 2'd3, 1'b0, 3'd0, 1'b0};

        idle(3);
        rst_n = 1'b1;

        for (int v = 0; v < 13; v++) begin
            tick();
            bus_if.key_pulse = tbl[v].pulse;
            bus_if.cmd_ready = tbl[v].ready;
            @(negedge clk);
            chk($sformatf("vec%0d valid", v), int'(bus_if.cmd_valid),  int'(tbl[v].ev));
            chk($sformatf("vec%0d key", v),   int'(bus_if.cmd_key),    int'(tbl[v].ek));
            chk($sformatf("vec%0d rep", v),   int'(bus_if.cmd_repeat), int'(tbl[v].er));
            chk($sformatf("vec%0d level", v), int'(bus_if.fifo_level), int'(tbl[v].el));
            chk($sformatf("vec%0d ovf", v),   int'(bus_if.overflow),   int'(tbl[v].eo));
        end

        // Test 3: held key 1 auto-repeats; held key 2 does not.
        tick();
        bus_if.key_pulse = 4'b0000;
        log_q.delete();
        tick();
        p = cyc;
        bus_if.key_pulse  = 4'b0010;
        bus_if.key_held_n = 4'b1101;
        bus_if.cmd_ready  = 1'b1;
        tick();
        bus_if.key_pulse = 4'b0000;
        while (cyc < p + 18) tick();
        bus_if.key_held_n = 4'b1111;
        while (cyc < p + 40) tick();
        exp_c = '{2, 10, 14, 18};
        exp_r = '{0, 1, 1, 1};
        chk("repeat count", log_q.size(), 4);
        for (int j = 0; j < 4 && j < log_q.size(); j++) begin
            chk($sformatf("repeat%0d cycle", j), log_q[j].c - p, exp_c[j]);
            chk($sformatf("repeat%0d key", j),   log_q[j].k, 1);
            chk($sformatf("repeat%0d flag", j),  log_q[j].r, exp_r[j]);
        end
        log_q.delete();
        tick();
        bus_if.key_pulse  = 4'b0100;
        bus_if.key_held_n = 4'b1011;
        tick();
        bus_if.key_pulse = 4'b0000;
        idle(30);
        bus_if.key_held_n = 4'b1111;
        idle(4);
        chk("norepeat count", log_q.size(), 1);
        if (log_q.size() > 0) begin
            chk("norepeat key", log_q[0].k, 2);
            chk("norepeat flag", log_q[0].r, 0);
        end

        // Test 4: saturate FIFO and pending bit, then overflow.
        log_q.delete();
        bus_if.cmd_ready = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick();
            bus_if.key_pulse = 4'b0001;
            if (n == 5) begin
                @(negedge clk);
                chk("sat level", int'(bus_if.fifo_level), 4);
                chk("sat ovf before", int'(bus_if.overflow), 0);
            end
            tick();
            bus_if.key_pulse = 4'b0000;
        end
        @(negedge clk);
        chk("sat ovf after", int'(bus_if.overflow), 1);
        chk("sat level after", int'(bus_if.fifo_level), 4);
        tick();
        bus_if.cmd_ready = 1'b1;
        idle(12);
        chk("sat drained", log_q.size(), 5);
        foreach (log_q[j]) chk($sformatf("sat entry%0d key", j), log_q[j].k, 0);
        chk("sat level empty", int'(bus_if.fifo_level), 0);
        chk("sat ovf sticky", int'(bus_if.overflow), 1);

        // Test 5: push+pop at level 2, then a stream that wraps the pointers.
        log_q.delete();
        tick();
        bus_if.key_pulse = 4'b1011;
        bus_if.cmd_ready = 1'b0;
        tick();
        bus_if.key_pulse = 4'b0000;
        tick();
        tick();
        bus_if.cmd_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("pushpop level", int'(bus_if.fifo_level), 2);
        chk("pushpop head", int'(bus_if.cmd_key), 1);
        seq = '{0, 1, 2, 3, 2, 1, 0, 3, 1, 2, 3, 0};
        exp_k = '{0, 1, 3};
        for (int s = 0; s < 12; s++) begin
            exp_k.push_back(seq[s]);
            tick();
            bus_if.key_pulse = 4'(1 << seq[s]);
            bus_if.cmd_ready = (cyc % 3) != 0;
            tick();
            bus_if.key_pulse = 4'b0000;
            bus_if.cmd_ready = (cyc % 3) != 0;
        end
        tick();
        bus_if.cmd_ready = 1'b1;
        idle(12);
        chk("wrap count", log_q.size(), exp_k.size());
        for (int j = 0; j < exp_k.size() && j < log_q.size(); j++) begin
            chk($sformatf("wrap entry%0d key", j), log_q[j].k, exp_k[j]);
            chk($sformatf("wrap entry%0d flag", j), log_q[j].r, 0);
        end

        // Test 6: reset with queued entries and a repeat timer running.
        log_q.delete();
        tick();
        bus_if.cmd_ready  = 1'b0;
        bus_if.key_held_n = 4'b1110;
        bus_if.key_pulse  = 4'b0001;
        tick();
        bus_if.key_pulse = 4'b1010;
        tick();
        bus_if.key_pulse = 4'b0000;
        idle(2);
        @(negedge clk);
        chk("prereset level", int'(bus_if.fifo_level), 3);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst valid", int'(bus_if.cmd_valid), 0);
        chk("rst key", int'(bus_if.cmd_key), 0);
        chk("rst rep", int'(bus_if.cmd_repeat), 0);
        chk("rst level", int'(bus_if.fifo_level), 0);
        chk("rst ovf", int'(bus_if.overflow), 0);
        idle(2);
        rst_n = 1'b1;
        bus_if.cmd_ready = 1'b1;
        idle(20);
        @(negedge clk);
        chk("postreset entries", log_q.size(), 0);
        chk("postreset level", int'(bus_if.fifo_level), 0);
        chk("postreset valid", int'(bus_if.cmd_valid), 0);
        bus_if.key_held_n = 4'b1111;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
